// File: rtl/hazard_stall_control_if.sv
// Shared opcode/writeback definitions and the hazard controller's port bundle.
// The decode/ID-EX/memory signals come in, and the stall/flush controls go out.
package hazard_pkg;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;
endpackage

interface hazard_stall_control_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic [6:0]             id_instr_opcode_ip;
  logic [4:0]             ID_src_rs1_ip;
  logic [4:0]             ID_src_rs2_ip;
  write_back_mux_selector ID_EX_wb_mux_ip;
  logic                   ID_EX_mem_read_ip;
  logic [4:0]             ID_EX_dest_ip;
  logic                   dmem_req_ip;
  logic                   dmem_ready_ip;
  logic                   branch_taken_ip;
  logic                   pc_stall_op;
  logic                   if_id_stall_op;
  logic                   id_ex_bubble_op;
  logic                   pipe_freeze_op;
  logic                   if_id_flush_op;
  logic [CNT_W-1:0]       stall_cnt_op;
  logic [CNT_W-1:0]       flush_cnt_op;

  modport master (
    output id_instr_opcode_ip, ID_src_rs1_ip, ID_src_rs2_ip,
    output ID_EX_wb_mux_ip, ID_EX_mem_read_ip, ID_EX_dest_ip,
    output dmem_req_ip, dmem_ready_ip, branch_taken_ip,
    input  pc_stall_op, if_id_stall_op, id_ex_bubble_op,
    input  pipe_freeze_op, if_id_flush_op,
    input  stall_cnt_op, flush_cnt_op
  );

  modport slave (
    input  id_instr_opcode_ip, ID_src_rs1_ip, ID_src_rs2_ip,
    input  ID_EX_wb_mux_ip, ID_EX_mem_read_ip, ID_EX_dest_ip,
    input  dmem_req_ip, dmem_ready_ip, branch_taken_ip,
    output pc_stall_op, if_id_stall_op, id_ex_bubble_op,
    output pipe_freeze_op, if_id_flush_op,
    output stall_cnt_op, flush_cnt_op
  );
endinterface

// File: rtl/hazard_stall_control.sv
// Load-use stall, memory-wait freeze and branch flush control,
// with saturating stall/flush cycle counters.
module hazard_stall_control
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  hazard_stall_control_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_use_rs1;
  logic w_use_rs2;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_load_use;
  logic w_mem_busy;
  logic w_freeze;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_bubble;
  logic w_pipe_freeze;
  logic w_flush;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    unique case (bus.id_instr_opcode_ip)
      OPCODE_OP,
      OPCODE_STORE,
      OPCODE_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPCODE_OPIMM,
      OPCODE_LOAD,
      OPCODE_JALR: w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign w_hit_rs1 = w_use_rs1 &&
    (bus.ID_src_rs1_ip == bus.ID_EX_dest_ip);
  assign w_hit_rs2 = w_use_rs2 &&
    (bus.ID_src_rs2_ip == bus.ID_EX_dest_ip);

  assign w_load_use = bus.ID_EX_mem_read_ip &&
    (bus.ID_EX_wb_mux_ip != NO_WRITEBACK) &&
    (bus.ID_EX_dest_ip != 5'd0) &&
    (w_hit_rs1 || w_hit_rs2);

  assign w_mem_busy = bus.dmem_req_ip && !bus.dmem_ready_ip;
  assign w_freeze   = (r_state == MEM_WAIT) || w_mem_busy;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:      if (w_mem_busy) w_next = MEM_WAIT;
      MEM_WAIT: if (bus.dmem_ready_ip) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  // Freeze beats branch: the branch stays held in EX until memory is done.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_bubble      = 1'b0;
    w_pipe_freeze = 1'b0;
    w_flush       = 1'b0;
    if (!reset) begin
      w_pc_stall = 1'b0;
    end else if (w_freeze) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_pipe_freeze = 1'b1;
    end else if (bus.branch_taken_ip) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_bubble      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_pc_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_stall_op     = w_pc_stall;
  assign bus.if_id_stall_op  = w_if_id_stall;
  assign bus.id_ex_bubble_op = w_bubble;
  assign bus.pipe_freeze_op  = w_pipe_freeze;
  assign bus.if_id_flush_op  = w_flush;
  assign bus.stall_cnt_op    = r_stall_cnt;
  assign bus.flush_cnt_op    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed plus random bench for hazard_stall_control,
// checked against a rule-level reference model.
module tb_hazard_stall_control;
  import hazard_pkg::*;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_control_if #(.CNT_W(W)) bus ();

  hazard_stall_control #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit m_wait;
  int m_stall;
  int m_flush;
  int base;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {pc_stall, if_id_stall, bubble, freeze, flush}.
  function automatic logic [4:0] model(input bit waiting);
    logic [4:0] srcs[2];
    int nsrc;
    bit lu;
    bit busy;
    srcs[0] = bus.ID_src_rs1_ip;
    srcs[1] = bus.ID_src_rs2_ip;
    case (bus.id_instr_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: nsrc = 2;
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: nsrc = 1;
      default: nsrc = 0;
    endcase
    lu = 1'b0;
    for (int i = 0; i < nsrc; i++)
      if (bus.ID_EX_mem_read_ip &&
          bus.ID_EX_wb_mux_ip != NO_WRITEBACK &&
          bus.ID_EX_dest_ip != 0 &&
          bus.ID_EX_dest_ip == srcs[i])
        lu = 1'b1;
    busy = bus.dmem_req_ip && !bus.dmem_ready_ip;
    if (waiting || busy) return 5'b11010;
    if (bus.branch_taken_ip) return 5'b00101;
    if (lu) return 5'b11100;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] ctrl();
    return {bus.pc_stall_op, bus.if_id_stall_op,
            bus.id_ex_bubble_op, bus.pipe_freeze_op,
            bus.if_id_flush_op};
  endfunction

  task automatic drive(
    input logic [6:0] op, input logic [4:0] rs1,
    input logic [4:0] rs2, input write_back_mux_selector wb,
    input logic memrd, input logic [4:0] dest,
    input logic req, input logic rdy, input logic br);
    bus.id_instr_opcode_ip = op;
    bus.ID_src_rs1_ip      = rs1;
    bus.ID_src_rs2_ip      = rs2;
    bus.ID_EX_wb_mux_ip    = wb;
    bus.ID_EX_mem_read_ip  = memrd;
    bus.ID_EX_dest_ip      = dest;
    bus.dmem_req_ip        = req;
    bus.dmem_ready_ip      = rdy;
    bus.branch_taken_ip    = br;
  endtask

  task automatic idle();
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string tag);
    logic [4:0] e;
    @(negedge clk);
    e = model(m_wait);
    chk({tag, ".ctrl"}, int'(ctrl()), int'(e));
    chk({tag, ".scnt"}, int'(bus.stall_cnt_op), m_stall);
    chk({tag, ".fcnt"}, int'(bus.flush_cnt_op), m_flush);
    @(posedge clk);
    if (e[4] && m_stall < MAX) m_stall++;
    if (e[0] && m_flush < MAX) m_flush++;
    m_wait = m_wait ? !bus.dmem_ready_ip
                    : (bus.dmem_req_ip && !bus.dmem_ready_ip);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, ".ctrl"}, int'(ctrl()), 0);
    chk({tag, ".scnt"}, int'(bus.stall_cnt_op), 0);
    chk({tag, ".fcnt"}, int'(bus.flush_cnt_op), 0);
    @(posedge clk);
    #1;
    m_wait  = 1'b0;
    m_stall = 0;
    m_flush = 0;
    idle();
    reset = 1'b1;
  endtask

  logic [6:0] ops[8];

  initial begin
    ops = '{OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH, OPCODE_OPIMM,
            OPCODE_LOAD, OPCODE_JALR, 7'h37, 7'h6F};
    idle();
    do_reset("rst0");

    // Load-use on rs1 of an R-type
    drive(OPCODE_OP, 5, 7, WB_MEM, 1, 5, 0, 0, 0);
    step("lu");
    chk("lu.cnt1", int'(bus.stall_cnt_op), 1);
    drive(OPCODE_OP, 1, 2, WB_ALU, 0, 6, 0, 0, 0);
    step("lu.after");
    drive(OPCODE_OP, 0, 7, WB_MEM, 1, 0, 0, 0, 0);
    step("lu.x0");

    // rs2 only counts for opcodes that read it
    drive(OPCODE_OPIMM, 3, 7, WB_MEM, 1, 7, 0, 0, 0);
    step("mask.opimm");
    drive(OPCODE_STORE, 3, 7, WB_MEM, 1, 7, 0, 0, 0);
    step("mask.store");
    idle();
    step("mask.after");

    // Memory wait: 3 busy cycles then ready
    base = m_stall;
    for (int i = 0; i < 3; i++) begin
      drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 1, 0, 0);
      step("mw.busy");
    end
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 0, 1, 0);
    step("mw.ready");
    idle();
    step("mw.run");
    chk("mw.cnt4", int'(bus.stall_cnt_op), base + 4);
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 1, 1, 0);
    step("mw.reqrdy");

    // Branch outranks load-use
    drive(OPCODE_OP, 5, 7, WB_MEM, 1, 5, 0, 0, 1);
    step("br.lu");
    chk("br.fcnt", int'(bus.flush_cnt_op), 1);
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 1, 0, 0);
    step("br.mw.enter");
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 0, 0, 1);
    step("br.mw.hold");
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 0, 1, 1);
    step("br.mw.exit");
    idle();
    step("br.after");

    // Reset in the middle of a memory wait with stall_cnt at 5
    do_reset("rst1");
    for (int i = 0; i < 5; i++) begin
      drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 1, 0, 0);
      step("rw.busy");
    end
    chk("rw.cnt5", int'(bus.stall_cnt_op), 5);
    do_reset("rst.mid");
    step("rw.run");

    // Saturation
    for (int i = 0; i < 20; i++) begin
      drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 1, 0, 0);
      step("sat.busy");
    end
    drive(7'h37, 0, 0, NO_WRITEBACK, 0, 0, 0, 1, 0);
    step("sat.ready");
    chk("sat.cnt15", int'(bus.stall_cnt_op), 15);

    do_reset("rst2");
    for (int i = 0; i < 300; i++) begin
      drive(ops[$urandom_range(0, 7)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            write_back_mux_selector'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
